// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the framed UART receiver.
// Optional feature macro: UART_FRAME_RX_CHECKSUM_EN (adds the CSUM byte/state).
package uart_frame_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
`ifdef UART_FRAME_RX_CHECKSUM_EN
    ST_CSUM    = 3'd3,
`endif
    ST_DRAIN   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_CSUM    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_t;

  // 8-bit wrapping checksum accumulate
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return 8'(acc + b);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x 8 registers, one synchronous write, one combinational read.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Framed UART receiver: hunts for SOF, collects LEN payload bytes (optionally
// checks a trailing checksum), then drains the payload over a valid/ready port.
// Optional feature macro: UART_FRAME_RX_CHECKSUM_EN.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 92160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_complete,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    wr_ptr_q, wr_ptr_d;
  logic [7:0]    rd_ptr_q, rd_ptr_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok_d, frame_err_d, out_valid_d, out_last_d, busy_d;
  logic [1:0]    err_code_d;
  logic [7:0]    out_data_d;
  logic          start_drain, wr_en_c, tmo_hit_c, fwd_c;
  logic [AW-1:0] rd_addr_c;
  logic [7:0]    rd_data_c;

  assign tmo_hit_c = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (AW'(wr_ptr_q)),
    .wdata (rx_data),
    .raddr (rd_addr_c),
    .rdata (rd_data_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    sum_d       = sum_q;
    tmo_d       = '0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code;
    out_valid_d = out_valid;
    start_drain = 1'b0;
    wr_en_c     = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        if (rx_complete && rx_data == SOF_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (rx_complete) begin
          if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = ST_HUNT;
          end else begin
            len_d    = rx_data;
            sum_d    = rx_data;
            wr_ptr_d = 8'd0;
            state_d  = ST_PAYLOAD;
          end
        end else if (tmo_hit_c) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_HUNT;
        end else begin
          tmo_d = TW'(tmo_q + 1'b1);
        end
      end
      ST_PAYLOAD: begin
        if (rx_complete) begin
          wr_en_c  = 1'b1;
          sum_d    = csum_add(sum_q, rx_data);
          wr_ptr_d = 8'(wr_ptr_q + 8'd1);
          if (wr_ptr_q == 8'(len_q - 8'd1)) begin
`ifdef UART_FRAME_RX_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            start_drain = 1'b1;
`endif
          end
        end else if (tmo_hit_c) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_HUNT;
        end else begin
          tmo_d = TW'(tmo_q + 1'b1);
        end
      end
`ifdef UART_FRAME_RX_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_complete) begin
          if (csum_add(sum_q, rx_data) == 8'd0) begin
            start_drain = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
            state_d     = ST_HUNT;
          end
        end else if (tmo_hit_c) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_HUNT;
        end else begin
          tmo_d = TW'(tmo_q + 1'b1);
        end
      end
`endif
      ST_DRAIN: begin
        if (rx_complete) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
        if (out_valid && out_ready) begin
          if (rd_ptr_q == 8'(len_q - 8'd1)) begin
            rd_ptr_d    = 8'd0;
            out_valid_d = 1'b0;
            state_d     = ST_HUNT;
          end else begin
            rd_ptr_d = 8'(rd_ptr_q + 8'd1);
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    if (start_drain) begin
      state_d     = ST_DRAIN;
      frame_ok_d  = 1'b1;
      out_valid_d = 1'b1;
      rd_ptr_d    = 8'd0;
    end

    // Forward the byte being written when a 1-byte frame starts draining at once
    rd_addr_c  = AW'(rd_ptr_d);
    fwd_c      = wr_en_c && (AW'(wr_ptr_q) == rd_addr_c);
    out_data_d = out_valid_d ? (fwd_c ? rx_data : rd_data_c) : out_data;
    out_last_d = out_valid_d && (rd_ptr_d == 8'(len_d - 8'd1));
    busy_d     = (state_d != ST_HUNT);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_HUNT;
      len_q     <= 8'd0;
      wr_ptr_q  <= 8'd0;
      rd_ptr_q  <= 8'd0;
      sum_q     <= 8'd0;
      tmo_q     <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      frame_ok  <= frame_ok_d;
      frame_err <= frame_err_d;
      err_code  <= err_code_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx (works with or without UART_FRAME_RX_CHECKSUM_EN).
module tb_uart_frame_rx;

  localparam int unsigned TB_TMO = 1000;
  localparam int unsigned TB_MAX = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_complete;
  logic [7:0] out_data;
  logic       out_valid, out_last, out_ready;
  logic       frame_ok, frame_err, busy;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_frame_rx #(.SOF_BYTE(8'hA5), .MAX_LEN(TB_MAX), .TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_complete(rx_complete),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int ok_cnt, err_cnt, both_cnt;
  logic [1:0] last_code;
  logic [7:0] got_data[$];
  logic       got_last[$];

  // Pulse counters and handshake capture, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_ok) ok_cnt++;
      if (frame_err) begin err_cnt++; last_code = err_code; end
      if (frame_ok && frame_err) both_cnt++;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    ok_cnt = 0; err_cnt = 0; last_code = 2'd0;
    got_data.delete(); got_last.delete();
  endtask

  task automatic send_raw(input logic [7:0] b);
    rx_data = b; rx_complete = 1'b1;
    tick();
    rx_complete = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b);
    tick(); tick();
  endtask

  function automatic logic [7:0] good_csum(input logic [7:0] len, input logic [7:0] pay[$]);
    logic [7:0] s;
    s = len;
    foreach (pay[i]) s = 8'(s + pay[i]);
    return 8'(8'd0 - s);
  endfunction

  task automatic send_frame(input logic [7:0] len, input logic [7:0] pay[$], input bit bad);
    send_byte(8'hA5);
    send_byte(len);
    foreach (pay[i]) send_byte(pay[i]);
`ifdef UART_FRAME_RX_CHECKSUM_EN
    if (pay.size() > 0) send_byte(bad ? 8'h00 : good_csum(len, pay));
`else
    if (bad) begin end
`endif
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin tick(); n++; end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    tick(); tick();
    check({name, "_valid_low"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic check_frame(input string name, input int exp_ok, input int exp_err,
                             input logic [1:0] exp_code, input logic [7:0] exp[$]);
    check({name, "_ok"}, ok_cnt, exp_ok);
    check({name, "_err"}, err_cnt, exp_err);
    if (exp_err > 0) check({name, "_code"}, {30'd0, last_code}, {30'd0, exp_code});
    check({name, "_nout"}, got_data.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_data.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), {24'd0, got_data[i]}, {24'd0, exp[i]});
      check($sformatf("%s_last%0d", name, i), {31'd0, got_last[i]},
            (i == exp.size() - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_reset_outs(input string name);
    check(name, {19'd0, out_valid, out_last, frame_ok, frame_err, busy, out_data, err_code}, 32'd0);
  endtask

  typedef struct packed {
    logic [7:0]      len;
    logic [2:0]      npay;
    logic [3:0][7:0] pay;
    logic            bad;
    logic [1:0]      ngarb;
    logic            exp_ok;
    logic            exp_err;
    logic [1:0]      exp_code;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] pay[$];
    logic [7:0] exp[$];
    logic [7:0] d0;
    bit stable;
    int n;

    vecs[0] = '{len:8'h03, npay:3'd3, pay:{8'h00, 8'h33, 8'h22, 8'h11}, bad:1'b0, ngarb:2'd0,
                exp_ok:1'b1, exp_err:1'b0, exp_code:2'd0};
    vecs[1] = '{len:8'h00, npay:3'd0, pay:'0, bad:1'b0, ngarb:2'd0,
                exp_ok:1'b0, exp_err:1'b1, exp_code:2'd1};
    vecs[2] = '{len:8'h41, npay:3'd0, pay:'0, bad:1'b0, ngarb:2'd0,
                exp_ok:1'b0, exp_err:1'b1, exp_code:2'd1};
    vecs[3] = '{len:8'h01, npay:3'd1, pay:{8'h00, 8'h00, 8'h00, 8'h7F}, bad:1'b0, ngarb:2'd2,
                exp_ok:1'b1, exp_err:1'b0, exp_code:2'd0};
`ifdef UART_FRAME_RX_CHECKSUM_EN
    vecs[4] = '{len:8'h02, npay:3'd2, pay:{8'h00, 8'h00, 8'h20, 8'h10}, bad:1'b1, ngarb:2'd0,
                exp_ok:1'b0, exp_err:1'b1, exp_code:2'd0};
`else
    vecs[4] = '{len:8'h02, npay:3'd2, pay:{8'h00, 8'h00, 8'h20, 8'h10}, bad:1'b1, ngarb:2'd0,
                exp_ok:1'b1, exp_err:1'b0, exp_code:2'd0};
`endif
    vecs[5] = '{len:8'h04, npay:3'd4, pay:{8'hDD, 8'hC3, 8'h00, 8'hA5}, bad:1'b0, ngarb:2'd1,
                exp_ok:1'b1, exp_err:1'b0, exp_code:2'd0};

    reset = 1'b1; rx_data = 8'h00; rx_complete = 1'b0; out_ready = 1'b1;
    both_cnt = 0;
    clear_mon();
    tick(); tick(); tick();
    check_reset_outs("reset_values");
    reset = 1'b0;
    tick();

    // Table of frames, consumer always ready
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      pay.delete(); exp.delete();
      for (int i = 0; i < int'(vecs[v].npay); i++) pay.push_back(vecs[v].pay[i]);
      if (vecs[v].exp_ok) exp = pay;
      for (int g = 0; g < int'(vecs[v].ngarb); g++) send_byte((g == 0) ? 8'h00 : 8'h5A);
      send_frame(vecs[v].len, pay, vecs[v].bad);
      wait_idle($sformatf("vec%0d", v));
      check_frame($sformatf("vec%0d", v), int'(vecs[v].exp_ok), int'(vecs[v].exp_err),
                  vecs[v].exp_code, exp);
    end

    // Inter-byte timeout fires after exactly TB_TMO idle cycles
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_raw(8'h10);
    n = 0;
    while (!frame_err && n < int'(TB_TMO) + 20) begin tick(); n++; end
    check("timeout_cycles", n, TB_TMO);
    check("timeout_code", {30'd0, err_code}, 32'd2);
    tick(); tick();
    check("timeout_busy", {31'd0, busy}, 32'd0);
    clear_mon();
    pay = '{8'h5C, 8'h01};
    send_frame(8'h02, pay, 1'b0);
    wait_idle("after_timeout");
    check_frame("after_timeout", 1, 0, 2'd0, pay);

    // Byte arriving on the expiry cycle wins over the timeout
    clear_mon();
    send_byte(8'hA5);
    send_raw(8'h02);
    for (int i = 0; i < int'(TB_TMO) - 1; i++) tick();
    send_byte(8'h10);
    check("coincide_no_err", err_cnt, 0);
    send_byte(8'h20);
`ifdef UART_FRAME_RX_CHECKSUM_EN
    send_byte(8'hCE);
`endif
    wait_idle("coincide");
    pay = '{8'h10, 8'h20};
    check_frame("coincide", 1, 0, 2'd0, pay);

    // Overrun while the consumer stalls
    clear_mon();
    out_ready = 1'b0;
    pay = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h03, pay, 1'b0);
    d0 = out_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_data !== d0 || out_last !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    check("stall_stable", {31'd0, stable}, 32'd1);
    check("stall_data", {24'd0, out_data}, 32'h11);
    send_byte(8'h7E);
    check("overrun_err", err_cnt, 1);
    check("overrun_code", {30'd0, last_code}, 32'd3);
    check("overrun_data_kept", {24'd0, out_data}, 32'h11);
    out_ready = 1'b1;
    wait_idle("overrun");
    check_frame("overrun", 1, 1, 2'd3, pay);

    // Reset after the 2nd payload byte
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick(); tick();
    check_reset_outs("midframe_reset");
    reset = 1'b0;
    tick(); tick();
    check("midframe_no_pulse", ok_cnt + err_cnt, 0);
    pay = '{8'h44, 8'h55};
    send_frame(8'h02, pay, 1'b0);
    wait_idle("after_reset");
    check_frame("after_reset", 1, 0, 2'd0, pay);

    // Largest legal frame with an intermittent consumer
    clear_mon();
    pay.delete();
    for (int i = 0; i < int'(TB_MAX); i++) pay.push_back(8'(i * 5 + 3));
    out_ready = 1'b0;
    send_frame(8'(TB_MAX), pay, 1'b0);
    n = 0;
    while (busy && n < 400) begin
      out_ready = (n % 3 != 2);
      tick();
      n++;
    end
    out_ready = 1'b1;
    wait_idle("maxlen");
    check_frame("maxlen", 1, 0, 2'd0, pay);

    check("ok_err_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
